// File: rtl/brightness_array_sequencer_if.sv
// Bus bundle between the block loader, the brightness systolic array and the
// output RAM on one side, and the job sequencer on the other.
interface brightness_array_sequencer_if #(
    parameter int PE_DATA_WIDTH = 16,
    parameter int DEPTH         = 4,
    parameter int ADDR_WIDTH    = 6
);
    logic                           start;
    logic [7:0]                     brightness;
    logic [PE_DATA_WIDTH*DEPTH-1:0] blk_data;
    logic                           blk_valid;
    logic                           blk_ready;
    logic [PE_DATA_WIDTH*DEPTH-1:0] pe_data;
    logic [DEPTH-1:0]               pe_valid;
    logic [PE_DATA_WIDTH-1:0]       pe_offset;
    logic [PE_DATA_WIDTH*DEPTH-1:0] arr_data;
    logic [DEPTH-1:0]               arr_valid;
    logic                           wr_en;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic [7:0]                     wr_data;
    logic                           busy;
    logic                           done;
    logic                           err;

    // Sequencer side
    modport slave (
        input  start, brightness, blk_data, blk_valid, arr_data, arr_valid,
        output blk_ready, pe_data, pe_valid, pe_offset, wr_en, wr_addr, wr_data,
               busy, done, err
    );

    // Loader / array / RAM side
    modport master (
        output start, brightness, blk_data, blk_valid, arr_data, arr_valid,
        input  blk_ready, pe_data, pe_valid, pe_offset, wr_en, wr_addr, wr_data,
               busy, done, err
    );
endinterface

// File: rtl/brightness_array_sequencer.sv
// Job controller for the 4x4 brightness systolic array: takes one block at a
// time, feeds its lanes to the array with a one-cycle-per-lane diagonal skew,
// gathers the per-lane results in any order, clamps them to a byte and writes
// them to the output RAM lane by lane. Pulses done after NUM_BLOCKS blocks.
module brightness_array_sequencer #(
    parameter int PE_DATA_WIDTH = 16,
    parameter int DEPTH         = 4,
    parameter int NUM_BLOCKS    = 16,
    parameter int ADDR_WIDTH    = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    brightness_array_sequencer_if.slave   bus
);
    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = $clog2(NUM_BLOCKS + 1);

    typedef enum logic [2:0] {IDLE, FEED, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t                    state_reg;
    logic [CW-1:0]             cnt_reg;       // lane counter shared by ISSUE and WRITE
    logic [CW-1:0]             cnt_inc;
    logic [BW-1:0]             blk_cnt_reg;
    logic [DEPTH-1:0]          mask_reg;
    logic [DEPTH-1:0]          pe_valid_reg;
    logic [DEPTH-1:0]          issue_next;
    logic [7:0]                brightness_reg;
    logic                      wr_en_reg;
    logic [ADDR_WIDTH-1:0]     wr_addr_reg;
    logic [ADDR_WIDTH-1:0]     blk_base;
    logic [7:0]                wr_data_reg;
    logic                      err_reg;
    logic                      accept;
    logic                      capturing;

    logic [PE_DATA_WIDTH-1:0]  blk_lane    [DEPTH];
    logic [PE_DATA_WIDTH-1:0]  arr_lane    [DEPTH];
    logic [PE_DATA_WIDTH-1:0]  hold_reg    [DEPTH];
    logic [PE_DATA_WIDTH-1:0]  res_reg     [DEPTH];
    logic [PE_DATA_WIDTH-1:0]  pe_lane_reg [DEPTH];

    // Unsigned saturation of an array result to one output byte
    function automatic logic [7:0] clamp(input logic [PE_DATA_WIDTH-1:0] v);
        return (v > PE_DATA_WIDTH'(255)) ? 8'hFF : v[7:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_lane
            assign blk_lane[gi] = bus.blk_data[gi*PE_DATA_WIDTH +: PE_DATA_WIDTH];
            assign arr_lane[gi] = bus.arr_data[gi*PE_DATA_WIDTH +: PE_DATA_WIDTH];
            assign bus.pe_data[gi*PE_DATA_WIDTH +: PE_DATA_WIDTH] = pe_lane_reg[gi];
        end
    endgenerate

    assign accept    = (state_reg == FEED) && bus.blk_valid;
    assign capturing = (state_reg == ISSUE) || (state_reg == WAIT);
    assign cnt_inc   = cnt_reg + CW'(1);
    assign blk_base  = ADDR_WIDTH'(blk_cnt_reg) * ADDR_WIDTH'(DEPTH);

    // Which lane gets its valid in the next cycle: lane 0 right after
    // acceptance, then one lane further per ISSUE cycle.
    always_comb begin
        issue_next = '0;
        if (accept)
            issue_next[0] = 1'b1;
        else if (state_reg == ISSUE && cnt_reg != CW'(DEPTH - 1))
            issue_next = DEPTH'(1) << cnt_inc;
    end

    // Main sequencer: state, skew registers, result capture, RAM writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            blk_cnt_reg    <= '0;
            mask_reg       <= '0;
            pe_valid_reg   <= '0;
            brightness_reg <= '0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= '0;
            err_reg        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                hold_reg[i]    <= '0;
                res_reg[i]     <= '0;
                pe_lane_reg[i] <= '0;
            end
        end else begin
            pe_valid_reg <= issue_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_next[i])
                    pe_lane_reg[i] <= accept ? blk_lane[i] : hold_reg[i];
                else
                    pe_lane_reg[i] <= '0;
            end

            // First arrival per lane is kept; repeats or stray results only flag err
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.arr_valid[i]) begin
                    if (capturing && !mask_reg[i]) begin
                        res_reg[i]  <= arr_lane[i];
                        mask_reg[i] <= 1'b1;
                    end else begin
                        err_reg <= 1'b1;
                    end
                end
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg      <= FEED;
                        brightness_reg <= bus.brightness;
                        blk_cnt_reg    <= '0;
                        mask_reg       <= '0;
                        err_reg        <= 1'b0;
                    end
                end
                FEED: begin
                    if (accept) begin
                        for (int i = 0; i < DEPTH; i++) hold_reg[i] <= blk_lane[i];
                        cnt_reg   <= '0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_reg == CW'(DEPTH - 1))
                        state_reg <= WAIT;
                    else
                        cnt_reg <= cnt_inc;
                end
                WAIT: begin
                    if (&mask_reg) begin
                        state_reg   <= WRITE;
                        cnt_reg     <= '0;
                        wr_en_reg   <= 1'b1;
                        wr_addr_reg <= blk_base;
                        wr_data_reg <= clamp(res_reg[0]);
                    end
                end
                WRITE: begin
                    if (cnt_reg == CW'(DEPTH - 1)) begin
                        wr_en_reg   <= 1'b0;
                        wr_addr_reg <= '0;
                        wr_data_reg <= '0;
                        blk_cnt_reg <= blk_cnt_reg + BW'(1);
                        if (blk_cnt_reg + BW'(1) == BW'(NUM_BLOCKS)) begin
                            state_reg <= DONE;
                        end else begin
                            state_reg <= FEED;
                            mask_reg  <= '0;
                        end
                    end else begin
                        cnt_reg     <= cnt_inc;
                        wr_addr_reg <= blk_base + ADDR_WIDTH'(cnt_inc);
                        wr_data_reg <= clamp(res_reg[cnt_inc]);
                    end
                end
                DONE: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.blk_ready = (state_reg == FEED);
    assign bus.pe_valid  = pe_valid_reg;
    assign bus.pe_offset = PE_DATA_WIDTH'(brightness_reg);
    assign bus.wr_en     = wr_en_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.busy      = (state_reg != IDLE) && (state_reg != DONE);
    assign bus.done      = (state_reg == DONE);
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_brightness_array_sequencer.sv
// Directed bench for brightness_array_sequencer: a table of blocks with
// hand-computed array results and expected RAM bytes, plus hand-written
// sequences for out-of-order results, duplicate results and mid-job reset.
module tb_brightness_array_sequencer;
    localparam int PE = 16;
    localparam int D  = 4;
    localparam int NB = 16;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;
    int   wr_count   = 0;
    int   done_count = 0;

    brightness_array_sequencer_if #(.PE_DATA_WIDTH(PE), .DEPTH(D), .ADDR_WIDTH(AW)) bus ();

    brightness_array_sequencer #(
        .PE_DATA_WIDTH(PE), .DEPTH(D), .NUM_BLOCKS(NB), .ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Event counters for whole-job totals
    always @(posedge clk) begin
        if (bus.wr_en) wr_count <= wr_count + 1;
        if (bus.done)  done_count <= done_count + 1;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [63:0] blk;
        logic [63:0] res;
        logic [31:0] exp;
        int          mode;   // 0: all lanes at once, 1: order 3,0,2,1 with gaps, 2: duplicate lane 2
    } vec_t;

    vec_t tab[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic [15:0] lane(input logic [63:0] v, input int i);
        return v[i*16 +: 16];
    endfunction

    task automatic drive_lanes(input logic [3:0] vmask, input logic [63:0] data);
        bus.arr_valid = vmask;
        bus.arr_data  = data;
    endtask

    // One block: feed, check skew, return results, check the four writes.
    // abort_at < 4 asserts reset just before that write is checked.
    task automatic run_block(input logic [63:0] blk, input logic [63:0] res,
                             input logic [31:0] exp, input int mode, input int idx,
                             input bit rand_valid, input int abort_at);
        bit acc;
        int guard;
        acc = 1'b0;
        guard = 0;
        while (!acc) begin
            if (guard > 60) begin
                check("accept_timeout", 64'd0, 64'd1);
                return;
            end
            bus.blk_data  = blk;
            bus.blk_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = bus.blk_ready && bus.blk_valid;
            tick();
            guard++;
        end
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        for (int i = 0; i < D; i++) begin
            check($sformatf("pe_valid b%0d c%0d", idx, i), bus.pe_valid, 64'(4'b0001 << i));
            check($sformatf("pe_data b%0d l%0d", idx, i), lane(bus.pe_data, i), lane(blk, i));
            check("blk_ready_issue", bus.blk_ready, 64'd0);
            tick();
        end
        check($sformatf("pe_valid_idle b%0d", idx), bus.pe_valid, 64'd0);
        case (mode)
            1: begin
                drive_lanes(4'b1000, res); tick();
                drive_lanes(4'b0000, '0);  tick();
                drive_lanes(4'b0001, res); tick();
                drive_lanes(4'b0100, res); tick();
                drive_lanes(4'b0000, '0);  tick(); tick();
                check("no_early_write", bus.wr_en, 64'd0);
                drive_lanes(4'b0010, res); tick();
                drive_lanes(4'b0000, '0);
            end
            2: begin
                drive_lanes(4'b0111, res); tick();
                drive_lanes(4'b0100, res ^ 64'h0000_00AA_0000_0000); tick();
                check("err_on_dup", bus.err, 64'd1);
                drive_lanes(4'b1000, res); tick();
                drive_lanes(4'b0000, '0);
            end
            default: begin
                drive_lanes(4'b1111, res); tick();
                drive_lanes(4'b0000, '0);
            end
        endcase
        guard = 0;
        while (!bus.wr_en && guard < 20) begin
            tick();
            guard++;
        end
        for (int j = 0; j < D; j++) begin
            if (j == abort_at) begin
                #2;
                reset = 1'b1;
                #1;
                check("abort_wr_en", bus.wr_en, 64'd0);
                check("abort_busy", bus.busy, 64'd0);
                check("abort_pe_offset", bus.pe_offset, 64'd0);
                check("abort_blk_ready", bus.blk_ready, 64'd0);
                return;
            end
            check($sformatf("wr_en b%0d w%0d", idx, j), bus.wr_en, 64'd1);
            check($sformatf("wr_addr b%0d w%0d", idx, j), bus.wr_addr, 64'(idx * 4 + j));
            check($sformatf("wr_data b%0d w%0d", idx, j), bus.wr_data, 64'(exp[j*8 +: 8]));
            check("blk_ready_write", bus.blk_ready, 64'd0);
            tick();
        end
        check($sformatf("wr_end b%0d", idx), bus.wr_en, 64'd0);
    endtask

    // Generated block: lanes idx*4+i+1, array result = lane + brightness (never saturates)
    task automatic gen_block(input int idx, input logic [7:0] br,
                             output logic [63:0] blk, output logic [63:0] res,
                             output logic [31:0] exp);
        for (int i = 0; i < D; i++) begin
            blk[i*16 +: 16] = 16'(idx * 4 + i + 1);
            res[i*16 +: 16] = 16'(idx * 4 + i + 1) + 16'(br);
            exp[i*8 +: 8]   = 8'(idx * 4 + i + 1) + br;
        end
    endtask

    task automatic start_job(input logic [7:0] br);
        bus.start      = 1'b1;
        bus.brightness = br;
        tick();
        bus.start      = 1'b0;
        bus.brightness = 8'h00;
        check("start_busy", bus.busy, 64'd1);
        check("start_blk_ready", bus.blk_ready, 64'd1);
        check("start_pe_offset", bus.pe_offset, 64'(br));
        check("start_err_clear", bus.err, 64'd0);
    endtask

    initial begin
        logic [63:0] blk;
        logic [63:0] res;
        logic [31:0] exp;
        int w0;
        int d0;

        tab[0] = '{blk: 64'h0004_0003_0002_0001, res: 64'h0014_0013_0012_0011, exp: 32'h14131211, mode: 0};
        tab[1] = '{blk: 64'h0008_0007_0006_0005, res: 64'h0080_FFFF_0100_00FF, exp: 32'h80FFFFFF, mode: 0};
        tab[2] = '{blk: 64'h000C_000B_000A_0009, res: 64'h001C_001B_001A_0019, exp: 32'h1C1B1A19, mode: 1};
        tab[3] = '{blk: 64'h0010_000F_000E_000D, res: 64'h0020_001F_001E_001D, exp: 32'h201F1E1D, mode: 2};

        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.brightness = 8'h00;
        bus.blk_data   = '0;
        bus.blk_valid  = 1'b0;
        bus.arr_data   = '0;
        bus.arr_valid  = '0;
        tick(); tick();
        check("rst_busy", bus.busy, 64'd0);
        check("rst_done", bus.done, 64'd0);
        check("rst_err", bus.err, 64'd0);
        check("rst_wr_en", bus.wr_en, 64'd0);
        check("rst_pe_valid", bus.pe_valid, 64'd0);
        check("rst_blk_ready", bus.blk_ready, 64'd0);
        check("rst_pe_offset", bus.pe_offset, 64'd0);
        reset = 1'b0;
        tick();

        // Job A: table blocks first, then generated blocks with random blk_valid
        w0 = wr_count;
        d0 = done_count;
        start_job(8'h10);
        for (int k = 0; k < NB; k++) begin
            if (k == 3) check("err_before_dup", bus.err, 64'd0);
            if (k < 4) begin
                run_block(tab[k].blk, tab[k].res, tab[k].exp, tab[k].mode, k, 1'b0, 4);
            end else begin
                gen_block(k, 8'h10, blk, res, exp);
                run_block(blk, res, exp, 0, k, 1'b1, 4);
            end
        end
        check("done_pulse", bus.done, 64'd1);
        check("done_busy", bus.busy, 64'd0);
        check("done_blk_ready", bus.blk_ready, 64'd0);
        check("err_sticky", bus.err, 64'd1);
        tick();
        check("done_one_cycle", bus.done, 64'd0);
        check("idle_busy", bus.busy, 64'd0);
        tick();
        check("job_a_writes", 64'(wr_count - w0), 64'd64);
        check("job_a_done_count", 64'(done_count - d0), 64'd1);

        // Job B: reset during the writes of block 5
        w0 = wr_count;
        start_job(8'h20);
        for (int k = 0; k < 5; k++) begin
            gen_block(k, 8'h20, blk, res, exp);
            run_block(blk, res, exp, 0, k, 1'b0, 4);
        end
        gen_block(5, 8'h20, blk, res, exp);
        run_block(blk, res, exp, 0, 5, 1'b0, 2);
        tick(); tick();
        check("reset_hold_wr_en", bus.wr_en, 64'd0);
        check("job_b_writes", 64'(wr_count - w0), 64'd22);
        reset = 1'b0;
        tick();

        // Job C: fresh job must restart at address 0
        start_job(8'h05);
        gen_block(0, 8'h05, blk, res, exp);
        run_block(blk, res, exp, 0, 0, 1'b0, 4);
        check("job_c_busy", bus.busy, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
